tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
- Bit-serial time-division demultiplexer; receive end of the team's 2-channel bit-interleaved TDM link.
- Transmit side alternates the mux select every bit: channel a, then channel b.
- Reassembles one WIDTH-bit word per channel per frame.
- Presents both words together on a registered valid/ready output.

Parameters:
WIDTH, 8, bits per channel word; frame length FRAME_BITS = 2*WIDTH (plus 1 with the optional feature); legal range 2..32

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  synchronous active-low reset
din  input  1  serial data bit
din_valid  input  1  din is sampled only in cycles with din_valid=1; gaps allowed
sync  input  1  frame start; qualified by din_valid; marks the bit in slot 0
out_a  output  WIDTH  reassembled channel a word
out_b  output  WIDTH  reassembled channel b word
out_valid  output  1  out_a/out_b hold a complete frame
out_ready  input  1  consumer accepts the frame when out_valid&&out_ready
overrun  output  1  1-cycle pulse: completed frame dropped because the buffer was still full
sync_err  output  1  1-cycle pulse: sync arrived mid-frame, so the partial frame was discarded
par_err  output  1  1-cycle pulse: parity mismatch; constant 0 unless the optional feature is compiled in

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n=0 at an edge):
  - state=IDLE, bit_cnt=0, shift registers=0.
  - out_a=0, out_b=0, out_valid=0, overrun=0, sync_err=0, par_err=0.
  - Reset mid-frame discards the partial frame.
  - Reset with out_valid=1 discards the buffered frame.
- Slot mapping:
  - Even slots (0,2,...) go to channel a; odd slots go to channel b.
  - Each channel is MSB first: slot 0 = a[WIDTH-1], slot 1 = b[WIDTH-1], slot 2*WIDTH-1 = b[0].
- State machine (2 states, bit_cnt width = clog2(FRAME_BITS)):
  - IDLE:
    - din_valid&&sync: capture din as slot 0, bit_cnt=1, go to SHIFT.
    - Otherwise hold; bits without sync are ignored.
  - SHIFT, on each din_valid cycle:
    - If sync=1: resync. Pulse sync_err, clear the shift registers, capture din as slot 0, bit_cnt=1.
    - Else: shift din into the channel selected by bit_cnt[0], then bit_cnt++.
    - When the last slot is captured: go to IDLE, bit_cnt=0, and raise the frame-complete event for that edge.
  - Cycles with din_valid=0 change no state.
- Frame-complete event:
  - Buffer free (out_valid=0, or out_valid&&out_ready this cycle): on the same edge load out_a/out_b from the shift paths, including the final bit, and set out_valid=1.
  - Latency: out_valid is high the cycle after the last bit is sampled.
  - Buffer full and not being drained: pulse overrun on the next cycle, drop the new frame, and leave out_a/out_b/out_valid unchanged.
- Output handshake:
  - out_valid falls on the edge after out_valid&&out_ready unless a new frame loads on that same edge.
  - Back-to-back loads are possible (throughput 1 frame per FRAME_BITS valid bits).
  - out_a/out_b stay stable while out_valid=1 and out_ready=0.
- Sync on the last slot takes the resync path. The current frame is not completed.
- Error pulses are registered, asserted for exactly one cycle, and may coincide.

Optional Feature:
- Macro TDM_DEMUX_PARITY_EN.
- Defined:
  - FRAME_BITS = 2*WIDTH+1; the trailing slot carries even parity over all 2*WIDTH data bits.
  - On mismatch: pulse par_err, drop the frame (no load, no overrun).
  - On match: normal completion.
- Undefined:
  - FRAME_BITS = 2*WIDTH; par_err tied to 0 and no parity logic is generated.

Decomposition:
- Package tdm_demux_pkg holds:
  - state enum {IDLE, SHIFT};
  - function frame_bits(width) returning FRAME_BITS under the macro;
  - localparam CNT_W.
- Natural sub-module tdm_chan_shift:
  - WIDTH-bit MSB-first shift register with shift-enable and synchronous clear;
  - instantiated twice, for channel a and channel b.

Test Plan:
- WIDTH=4, out_ready=1. Send sync plus serial 1,0,0,1,1,1,0,0 on consecutive cycles -> one cycle after the last bit: out_a=4'b1010, out_b=4'b0110, out_valid=1; no error pulses.
- Same frame with din_valid=0 gaps between bits -> identical output; out_valid rises one cycle after the 8th valid bit.
- out_ready=0. Send two frames (a=4'hF,b=4'h0 then a=4'h3,b=4'h5) -> out_a=4'hF/out_b=4'h0 held; overrun pulses once after frame 2. Then raise out_ready -> out_valid drops next cycle.
- Send 3 bits, then sync plus a full frame a=4'h9,b=4'h6 -> sync_err pulses once; output a=4'h9,b=4'h6.
- Pulse rst_n=0 for one cycle mid-frame and while out_valid=1 -> all outputs 0 next cycle; bits without sync are ignored until the next sync.
- TDM_DEMUX_PARITY_EN: frame a=4'hA,b=4'h6 with parity bit 0 -> loads. Same frame with parity bit 1 -> par_err pulse, out_valid stays 0.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared state type, frame length and counter sizing for tdm_demux (TDM_DEMUX_PARITY_EN adds a parity slot)
package tdm_demux_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic int frame_bits(input int width);
`ifdef TDM_DEMUX_PARITY_EN
    return 2 * width + 1;
`else
    return 2 * width;
`endif
  endfunction
  localparam int MAX_WIDTH = 32;
  localparam int CNT_W = $clog2(frame_bits(MAX_WIDTH));
endpackage

// File: rtl/tdm_chan_shift.sv
// tdm_chan_shift: MSB-first channel shift register with shift-enable and synchronous clear
module tdm_chan_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] base;
  // clear and shift on the same edge means "start over with d as the first bit"
  always_comb base = clr ? '0 : q;
  always_ff @(posedge clk)
    if (!rst_n) q <= '0;
    else if (clr || en) q <= en ? {base[WIDTH-2:0], d} : base;
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: 2-channel bit-interleaved TDM receiver; rebuilds a/b words and offers them on valid/ready
// Build option TDM_DEMUX_PARITY_EN appends an even-parity slot checked before each frame is loaded.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             sync_err,
  output logic             par_err
);
  localparam int FB = frame_bits(WIDTH);
  localparam int CW = $clog2(FB) < CNT_W ? $clog2(FB) : CNT_W;
  state_t state;
  logic [CW-1:0] bit_cnt;
  logic [WIDTH-1:0] sh_a, sh_b, load_b;
  logic take, resync, shifting, last, data, done, free, en_a, en_b;
  assign take     = din_valid && sync;
  assign resync   = take && state == SHIFT;
  assign shifting = din_valid && !sync && state == SHIFT;
  assign last     = shifting && bit_cnt == CW'(FB - 1);
  assign free     = !out_valid || out_ready;
  assign en_a     = take || (data && !bit_cnt[0]);
  assign en_b     = data && bit_cnt[0];
`ifdef TDM_DEMUX_PARITY_EN
  logic par_q;
  // trailing slot is parity only; data bits plus parity must XOR to zero
  assign data    = shifting && !last;
  assign done    = last && !(^{sh_a, sh_b, din});
  assign load_b  = sh_b;
  assign par_err = par_q;
  always_ff @(posedge clk) par_q <= rst_n && last && (^{sh_a, sh_b, din});
`else
  // last slot is b[0]; bypass it straight into the output so the load happens on this edge
  assign data    = shifting;
  assign done    = last;
  assign load_b  = {sh_b[WIDTH-2:0], din};
  assign par_err = 1'b0;
`endif
  tdm_chan_shift #(.WIDTH(WIDTH)) u_chan_a (.clk(clk), .rst_n(rst_n), .clr(take), .en(en_a), .d(din), .q(sh_a));
  tdm_chan_shift #(.WIDTH(WIDTH)) u_chan_b (.clk(clk), .rst_n(rst_n), .clr(take), .en(en_b), .d(din), .q(sh_b));
  always_ff @(posedge clk)
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      sync_err <= resync;
      overrun  <= done && !free;
      if (take) begin
        state   <= SHIFT;
        bit_cnt <= CW'(1);
      end else if (last) begin
        state   <= IDLE;
        bit_cnt <= '0;
      end else if (shifting) bit_cnt <= bit_cnt + CW'(1);
      if (done && free) begin
        out_a     <= sh_a;
        out_b     <= load_b;
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed plus random checks of tdm_demux (WIDTH=4) against a slot-array reference model
module tb_tdm_demux;
  localparam int W = 4;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FB = 2 * W + 1;
`else
  localparam int FB = 2 * W;
`endif
  logic clk = 0, rst_n = 0, din = 0, din_valid = 0, sync = 0, out_ready = 1;
  logic [W-1:0] out_a, out_b;
  logic out_valid, overrun, sync_err, par_err;
  int vectors = 0, miscompares = 0;
  bit m_active;
  int m_slot;
  bit m_bits[FB];
  logic [W-1:0] m_a, m_b;
  bit m_valid, m_ovr, m_serr, m_perr;

  always #5 clk = ~clk;

  tdm_demux #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
    .out_a(out_a), .out_b(out_b), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .sync_err(sync_err), .par_err(par_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // frame-level model: collect slots into an array, build words arithmetically on completion
  task automatic model_step(input bit r, input bit v, input bit s, input bit d, input bit rdy);
    bit done, drain, pbit;
    int a, b;
    done = 0;
    m_ovr = 0;
    m_serr = 0;
    m_perr = 0;
    if (!r) begin
      m_active = 0; m_slot = 0; m_a = 0; m_b = 0; m_valid = 0;
      return;
    end
    drain = m_valid && rdy;
    if (v && s) begin
      if (m_active) m_serr = 1;
      m_active = 1; m_slot = 1; m_bits[0] = d;
    end else if (v && m_active) begin
      m_bits[m_slot] = d;
      m_slot++;
      if (m_slot == FB) begin m_active = 0; done = 1; end
    end
    if (done && FB != 2 * W) begin
      pbit = 0;
      for (int i = 0; i < 2 * W; i++) pbit ^= m_bits[i];
      if (pbit != m_bits[2 * W]) begin m_perr = 1; done = 0; end
    end
    if (done) begin
      a = 0; b = 0;
      for (int i = 0; i < W; i++) begin
        a = a * 2 + int'(m_bits[2 * i]);
        b = b * 2 + int'(m_bits[2 * i + 1]);
      end
      if (!m_valid || drain) begin
        m_a = W'(a); m_b = W'(b); m_valid = 1;
      end else m_ovr = 1;
    end else if (drain) m_valid = 0;
  endtask

  task automatic cyc(input bit r, input bit v, input bit s, input bit d, input bit rdy);
    rst_n = r; din_valid = v; sync = s; din = d; out_ready = rdy;
    @(posedge clk);
    #1;
    model_step(r, v, s, d, rdy);
    chk("out_a", out_a, m_a);
    chk("out_b", out_b, m_b);
    chk("out_valid", out_valid, m_valid);
    chk("overrun", overrun, m_ovr);
    chk("sync_err", sync_err, m_serr);
    chk("par_err", par_err, m_perr);
  endtask

  task automatic send_bits(input logic [W-1:0] a, input logic [W-1:0] b, input int from, input int gap, input bit rdy);
    bit bt;
    for (int i = from; i < FB; i++) begin
      if (i > from) repeat (gap) cyc(1, 0, 0, 1'($urandom), rdy);
      if (i == 2 * W) bt = ^{a, b};
      else bt = (i % 2 == 0) ? a[W - 1 - i / 2] : b[W - 1 - i / 2];
      cyc(1, 1, i == 0, bt, rdy);
    end
  endtask

  initial begin
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 1, 1, 1);
    chk("rst_a", out_a, 0);
    chk("rst_valid", out_valid, 0);
    cyc(1, 0, 0, 0, 1);
    // slots 1,0,0,1,1,1,0,0 -> a=1010, b=0110
    send_bits(4'b1010, 4'b0110, 0, 0, 1);
    chk("t1_a", out_a, 4'hA);
    chk("t1_b", out_b, 4'h6);
    chk("t1_valid", out_valid, 1);
    cyc(1, 0, 0, 0, 1);
    chk("t1_drain", out_valid, 0);
    send_bits(4'b1010, 4'b0110, 0, 2, 1);
    chk("t2_a", out_a, 4'hA);
    chk("t2_b", out_b, 4'h6);
    chk("t2_valid", out_valid, 1);
    cyc(1, 0, 0, 0, 1);
    send_bits(4'hF, 4'h0, 0, 0, 0);
    chk("t3_valid", out_valid, 1);
    send_bits(4'h3, 4'h5, 0, 1, 0);
    chk("t3_overrun", overrun, 1);
    chk("t3_a_held", out_a, 4'hF);
    chk("t3_b_held", out_b, 4'h0);
    cyc(1, 0, 0, 0, 0);
    chk("t3_ovr_once", overrun, 0);
    cyc(1, 0, 0, 0, 1);
    chk("t3_drop", out_valid, 0);
    cyc(1, 1, 1, 0, 1);
    cyc(1, 1, 0, 1, 1);
    cyc(1, 1, 0, 1, 1);
    cyc(1, 1, 1, 1, 1);
    chk("t4_serr", sync_err, 1);
    send_bits(4'h9, 4'h6, 1, 0, 1);
    chk("t4_a", out_a, 4'h9);
    chk("t4_b", out_b, 4'h6);
    chk("t4_serr_once", sync_err, 0);
    cyc(1, 1, 1, 1, 1);
    cyc(1, 1, 0, 1, 1);
    cyc(0, 1, 0, 1, 1);
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_a", out_a, 0);
    for (int i = 0; i < FB + 2; i++) cyc(1, 1, 0, 1'($urandom), 1);
    chk("t5_nosync", out_valid, 0);
    send_bits(4'h5, 4'hC, 0, 0, 0);
    chk("t5_load", out_valid, 1);
    cyc(0, 0, 0, 0, 0);
    chk("t5_rst_full", out_valid, 0);
    chk("t5_rst_b", out_b, 0);
    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(199) != 0, $urandom_range(3) != 0, $urandom_range(11) == 0,
          1'($urandom), 1'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
